fft_readout_bridge: RTL and testbench
=====================================

FFT_READOUT_BRIDGE -- requirements
Module: fft_readout_bridge

Interface
REQ-001 SHALL have parameter NFFT_LOG2, default 9, giving log2 of the bin count per frame (512 bins).
REQ-002 SHALL have parameter BIN_WIDTH, default 32, giving bits per bin; legal values are 8, 16, 24 and 32.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, giving the host byte-address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port bin_valid, input, 1 bit: bin_index/bin_data valid this cycle.
REQ-007 SHALL have port bin_index, input, NFFT_LOG2 bits: bin number being written.
REQ-008 SHALL have port bin_data, input, BIN_WIDTH bits: unsigned bin magnitude.
REQ-009 SHALL have port frame_end, input, 1 bit: one-cycle pulse marking a completed frame.
REQ-010 SHALL have port chipselect, input, 1 bit: high while the host is reading a frame.
REQ-011 SHALL have port address, input, ADDR_WIDTH bits: host byte address.
REQ-012 SHALL have port readdata, output, 8 bits: byte at the address sampled in the previous cycle.
REQ-013 SHALL have port frame_ready, output, 1 bit: one-cycle pulse on each bank swap.

Function
REQ-014 SHALL keep two bin banks: the read bank is visible to the host, the write bank is filled by the pipeline.
REQ-015 SHALL write bin_data to the write bank at bin_index on every bin_valid cycle, unless a swap is pending.
REQ-016 SHALL, on frame_end with chipselect low in the same cycle, swap banks at that edge, increment the 32-bit wrapping frame counter, and pulse frame_ready the next cycle.
REQ-017 SHALL, on frame_end with chipselect high, set pending=1 and perform the swap on the first cycle chipselect is low.
REQ-018 SHALL, while pending=1, drop all bin_valid writes.
REQ-019 SHALL, on frame_end while pending=1, increment the 16-bit overrun counter, saturating at 0xFFFF, and leave pending set.
REQ-020 SHALL, when bin_valid and frame_end occur in the same cycle, write the bin as part of the ending frame.
REQ-021 SHALL leave unwritten bins of a partial frame holding stale bank contents.
REQ-022 SHALL take the header snapshot (frame counter, overrun counter, status) every cycle chipselect is low, and hold it while chipselect is high.
REQ-023 SHALL register readdata with 1-cycle latency and update it every cycle regardless of chipselect.
REQ-024 SHALL decode byte addresses, all multi-byte fields little-endian, as follows:
- 0-3: frame counter
- 4-5: overrun counter
- 6: bit0 = read bank, bit1 = pending, other bits 0
- 7: 0
- 8-11: peak index
- 12-15: peak magnitude
- 16 + k*(BIN_WIDTH/8) + b: byte b of bin k
- any other address: 0

Reset
REQ-025 SHALL, while reset is low at a clock edge, clear the frame counter, overrun counter, pending, read-bank select, peak registers, readdata and frame_ready.
REQ-026 SHALL NOT reset bank contents; bin reads before the first swap are undefined.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame; the next frame_end after release swaps normally.

Configuration
REQ-028 SHALL, with PEAK_TRACK_EN defined, track the maximum bin_data and its bin_index over accepted writes. Ties keep the lower index. The tracker clears at each swap and is published to addresses 8-15 at the swap.
REQ-029 SHALL, without PEAK_TRACK_EN, contain no peak logic and read 0 at addresses 8-15.

Structure
REQ-030 SHALL place address offset constants (FRAME_CNT=0, OVR_CNT=4, STATUS=6, PEAK_IDX=8, PEAK_MAG=12, BIN_BASE=16) and the parameter defaults in package fft_readout_pkg.
REQ-031 SHALL implement the banks as sub-module bin_bank_ram, with 2 x 2^NFFT_LOG2 words, one write port, one registered read port, and a bank-select bit on each port.

Verification
REQ-032 SHALL cover: write bins 0..511 with data=index*3, frame_end, chipselect low -> frame_ready pulse one cycle later; addr 0 reads 0x01; addr 16+4*5 reads 0x0F.
REQ-033 SHALL cover: frame_end with chipselect high -> byte 6 reads 0x02 and bins stay old; drop chipselect -> swap that cycle, frame_ready pulse, byte 6 reads 0x01.
REQ-034 SHALL cover: three frame_end pulses while chipselect is held high -> overrun reads 0x0002 after release; bins written during pending are absent.
REQ-035 SHALL cover: overrun preloaded via 70000 blocked frames -> addr 4/5 read 0xFF/0xFF.
REQ-036 SHALL cover, with PEAK_TRACK_EN: bins 7 and 300 both 0xABCD, all others smaller -> peak index reads 7, peak magnitude 0x0000ABCD; without the macro -> bytes 8-15 read 0.
REQ-037 SHALL cover: reset low mid-frame, then one full frame -> frame counter reads 1, read bank 1.

Source files
------------

// File: rtl/fft_readout_pkg.sv
// Shared constants for the FFT readout bridge: host address map and parameter defaults.
package fft_readout_pkg;

    localparam int NFFT_LOG2_DEF  = 9;
    localparam int BIN_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 16;

    localparam int FRAME_CNT = 0;
    localparam int OVR_CNT   = 4;
    localparam int STATUS    = 6;
    localparam int PEAK_IDX  = 8;
    localparam int PEAK_MAG  = 12;
    localparam int BIN_BASE  = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bin_bank_ram.sv
// Two-bank bin storage: one write port, one registered read port, bank bit on each.
module bin_bank_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**(AW+1)];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank, wr_addr}] <= wr_data;
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/fft_readout_bridge.sv
// Double-buffered FFT bin readout with byte-addressed host port.
// Optional peak tracker enabled by defining PEAK_TRACK_EN.
module fft_readout_bridge
    import fft_readout_pkg::*;
#(
    parameter int NFFT_LOG2  = NFFT_LOG2_DEF,
    parameter int BIN_WIDTH  = BIN_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bin_valid,
    input  logic [NFFT_LOG2-1:0]  bin_index,
    input  logic [BIN_WIDTH-1:0]  bin_data,
    input  logic                  frame_end,
    input  logic                  chipselect,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            readdata,
    output logic                  frame_ready
);

    localparam int NB    = BIN_WIDTH / 8;
    localparam int NBINS = 1 << NFFT_LOG2;

    logic        rd_bank;
    logic        pending;
    logic [31:0] frame_cnt;
    logic [15:0] ovr_cnt;
    logic [31:0] snap_frame;
    logic [15:0] snap_ovr;
    logic        snap_bank;

    logic        swap;
    logic        we;
    logic        pend_n;
    logic [15:0] ovr_n;
    logic [31:0] frame_n;

    always_comb begin
        swap    = !chipselect && (pending || frame_end);
        we      = bin_valid && !pending;
        pend_n  = pending;
        if (swap)
            pend_n = 1'b0;
        else if (frame_end)
            pend_n = 1'b1;
        ovr_n   = (frame_end && pending) ? sat_inc16(ovr_cnt) : ovr_cnt;
        frame_n = frame_cnt + 32'(swap);
    end

    // Snapshot takes next-state values so it is coherent with the swap edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_bank     <= 1'b0;
            pending     <= 1'b0;
            frame_cnt   <= '0;
            ovr_cnt     <= '0;
            snap_frame  <= '0;
            snap_ovr    <= '0;
            snap_bank   <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            rd_bank     <= rd_bank ^ swap;
            pending     <= pend_n;
            frame_cnt   <= frame_n;
            ovr_cnt     <= ovr_n;
            frame_ready <= swap;
            if (!chipselect) begin
                snap_frame <= frame_n;
                snap_ovr   <= ovr_n;
                snap_bank  <= rd_bank ^ swap;
            end
        end
    end

    logic [63:0] peak_field;

`ifdef PEAK_TRACK_EN
    logic                 pk_any;
    logic [NFFT_LOG2-1:0] pk_idx;
    logic [NFFT_LOG2-1:0] pub_idx;
    logic [BIN_WIDTH-1:0] pk_mag;
    logic [BIN_WIDTH-1:0] pub_mag;
    logic                 take;

    // Strict compare on magnitude; ties go to the lower bin index.
    assign take = we && (!pk_any || bin_data > pk_mag ||
                  (bin_data == pk_mag && bin_index < pk_idx));

    always_ff @(posedge clk) begin
        if (!reset) begin
            pk_any  <= 1'b0;
            pk_idx  <= '0;
            pk_mag  <= '0;
            pub_idx <= '0;
            pub_mag <= '0;
        end else if (swap) begin
            pub_idx <= take ? bin_index : pk_idx;
            pub_mag <= take ? bin_data : pk_mag;
            pk_any  <= 1'b0;
            pk_idx  <= '0;
            pk_mag  <= '0;
        end else if (take) begin
            pk_any <= 1'b1;
            pk_idx <= bin_index;
            pk_mag <= bin_data;
        end
    end

    assign peak_field = {32'(pub_mag), 32'(pub_idx)};
`else
    assign peak_field = '0;
`endif

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] kq;
    logic [ADDR_WIDTH-1:0] bq;
    logic                  in_bins;
    logic [127:0]          hdr;
    logic [7:0]            hdr_byte;

    // Pending is shown live so the host can see a waiting swap while selected.
    always_comb begin
        off     = address - ADDR_WIDTH'(BIN_BASE);
        kq      = off / ADDR_WIDTH'(NB);
        bq      = off % ADDR_WIDTH'(NB);
        in_bins = (address >= ADDR_WIDTH'(BIN_BASE)) &&
                  (32'(kq) < 32'(NBINS));
        hdr = '0;
        hdr[FRAME_CNT*8 +: 32] = snap_frame;
        hdr[OVR_CNT*8 +: 16]   = snap_ovr;
        hdr[STATUS*8 +: 8]     = {6'b0, pending, snap_bank};
        hdr[PEAK_IDX*8 +: 64]  = peak_field;
        hdr_byte = '0;
        if (address < ADDR_WIDTH'(16))
            hdr_byte = hdr[8*address[3:0] +: 8];
    end

    logic [7:0]            hdr_q;
    logic                  use_bin_q;
    logic [ADDR_WIDTH-1:0] b_q;
    logic [BIN_WIDTH-1:0]  rd_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hdr_q     <= '0;
            use_bin_q <= 1'b0;
            b_q       <= '0;
        end else begin
            hdr_q     <= hdr_byte;
            use_bin_q <= in_bins;
            b_q       <= bq;
        end
    end

    bin_bank_ram #(
        .AW (NFFT_LOG2),
        .DW (BIN_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (we),
        .wr_bank (!rd_bank),
        .wr_addr (bin_index),
        .wr_data (bin_data),
        .rd_bank (rd_bank),
        .rd_addr (kq[NFFT_LOG2-1:0]),
        .rd_data (rd_word)
    );

    assign readdata = use_bin_q ? 8'(rd_word >> {b_q, 3'b000}) : hdr_q;

endmodule

// File: tb/tb_fft_readout_bridge.sv
// Directed self-checking bench for fft_readout_bridge (default parameters).
module tb_fft_readout_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        bin_valid;
    logic [8:0]  bin_index;
    logic [31:0] bin_data;
    logic        frame_end;
    logic        chipselect;
    logic [15:0] address;
    logic [7:0]  readdata;
    logic        frame_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp;
        string       nm;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] pk_exp [8];

    fft_readout_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .bin_valid   (bin_valid),
        .bin_index   (bin_index),
        .bin_data    (bin_data),
        .frame_end   (frame_end),
        .chipselect  (chipselect),
        .address     (address),
        .readdata    (readdata),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int kind, input int i);
        case (kind)
            0: return 32'(i * 3);
            1: return (i == 7 || i == 300) ? 32'hABCD : 32'h1000 + 32'(i);
            2: return 32'h2000 + 32'(i);
            3: return 32'h3000 + 32'(i);
            4: return 32'h7700 + 32'(i);
            5: return 32'h4400 + 32'(i);
            default: return 32'hEE;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e,
                      input string nm);
        address = a;
        step();
        chk(nm, 32'(readdata), 32'(e));
    endtask

    task automatic frame(input int kind, input int n, input bit fe_last);
        for (int i = 0; i < n; i++) begin
            bin_valid = 1'b1;
            bin_index = 9'(i);
            bin_data  = pat(kind, i);
            frame_end = fe_last && (i == n - 1);
            step();
        end
        bin_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic add(input logic [15:0] a, input logic [7:0] e,
                       input string nm);
        vec_t v;
        v.addr = a;
        v.exp  = e;
        v.nm   = nm;
        tbl.push_back(v);
    endtask

    initial begin
        add(16'd0,    8'h01, "f1_fcnt_b0");
        add(16'd1,    8'h00, "f1_fcnt_b1");
        add(16'd3,    8'h00, "f1_fcnt_b3");
        add(16'd4,    8'h00, "f1_ovr_b0");
        add(16'd5,    8'h00, "f1_ovr_b1");
        add(16'd6,    8'h01, "f1_status");
        add(16'd7,    8'h00, "f1_byte7");
        add(16'd16,   8'h00, "f1_bin0");
        add(16'd36,   8'h0F, "f1_bin5_b0");
        add(16'd37,   8'h00, "f1_bin5_b1");
        add(16'd416,  8'h2C, "f1_bin100_b0");
        add(16'd417,  8'h01, "f1_bin100_b1");
        add(16'd2060, 8'hFD, "f1_bin511_b0");
        add(16'd2061, 8'h05, "f1_bin511_b1");
        add(16'd2063, 8'h00, "f1_bin511_b3");
        add(16'd2064, 8'h00, "f1_past_end");
        add(16'hFFFF, 8'h00, "f1_top_addr");
`ifdef PEAK_TRACK_EN
        pk_exp = '{8'h07, 8'h00, 8'h00, 8'h00, 8'hCD, 8'hAB, 8'h00, 8'h00};
`else
        pk_exp = '{default: 8'h00};
`endif

        reset = 1'b0;
        bin_valid = 1'b0;
        bin_index = '0;
        bin_data = '0;
        frame_end = 1'b0;
        chipselect = 1'b0;
        address = '0;
        repeat (3) step();
        chk("rst_readdata", 32'(readdata), 32'h0);
        chk("rst_frame_ready", 32'(frame_ready), 32'h0);
        reset = 1'b1;
        chipselect = 1'b1;
        rd(16'd0, 8'h00, "rst_fcnt");
        rd(16'd6, 8'h00, "rst_status");

        // partial frame, then reset mid-frame
        chipselect = 1'b0;
        frame(6, 10, 1'b0);
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;

        frame(0, 512, 1'b1);
        chk("f1_ready", 32'(frame_ready), 32'h1);
        step();
        chk("f1_ready_drop", 32'(frame_ready), 32'h0);
        chipselect = 1'b1;
        foreach (tbl[i])
            rd(tbl[i].addr, tbl[i].exp, tbl[i].nm);

        chipselect = 1'b0;
        frame(1, 512, 1'b1);
        chk("f2_ready", 32'(frame_ready), 32'h1);
        chipselect = 1'b1;
        for (int i = 0; i < 8; i++)
            rd(16'(8 + i), pk_exp[i], $sformatf("peak_b%0d", 8 + i));
        rd(16'd6, 8'h00, "f2_status");

        // swap deferred while host is selected
        frame(2, 512, 1'b0);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk("pend_no_ready", 32'(frame_ready), 32'h0);
        rd(16'd6, 8'h02, "pend_status");
        rd(16'd37, 8'h10, "pend_old_bin");
        chipselect = 1'b0;
        address = 16'd6;
        step();
        chk("release_ready", 32'(frame_ready), 32'h1);
        chipselect = 1'b1;
        rd(16'd6, 8'h01, "release_status");
        rd(16'd37, 8'h20, "release_new_bin");
        rd(16'd0, 8'h03, "release_fcnt");

        // three frame_end pulses while selected
        frame(3, 512, 1'b1);
        chk("ovr_no_ready", 32'(frame_ready), 32'h0);
        frame(4, 20, 1'b1);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chipselect = 1'b0;
        step();
        chk("ovr_release_ready", 32'(frame_ready), 32'h1);
        chipselect = 1'b1;
        rd(16'd4, 8'h02, "ovr_b0");
        rd(16'd5, 8'h00, "ovr_b1");
        rd(16'd0, 8'h04, "ovr_fcnt");
        rd(16'd6, 8'h00, "ovr_status");
        rd(16'd37, 8'h30, "ovr_bin5_b1");
        rd(16'd57, 8'h30, "ovr_bin10_b1");
        rd(16'd56, 8'h0A, "ovr_bin10_b0");

        // partial frame keeps stale bins
        chipselect = 1'b0;
        frame(5, 4, 1'b1);
        chk("part_ready", 32'(frame_ready), 32'h1);
        chipselect = 1'b1;
        rd(16'd25, 8'h44, "part_bin2_b1");
        rd(16'd24, 8'h02, "part_bin2_b0");
        rd(16'd57, 8'h20, "stale_bin10_b1");
        rd(16'd56, 8'h0A, "stale_bin10_b0");
        rd(16'd0, 8'h05, "part_fcnt");
        rd(16'd6, 8'h01, "part_status");

        // saturate the overrun counter
        frame_end = 1'b1;
        repeat (70001) step();
        frame_end = 1'b0;
        rd(16'd4, 8'h02, "sat_held_ovr");
        rd(16'd6, 8'h03, "sat_pend_status");
        chipselect = 1'b0;
        step();
        chk("sat_ready", 32'(frame_ready), 32'h1);
        chipselect = 1'b1;
        rd(16'd4, 8'hFF, "sat_ovr_b0");
        rd(16'd5, 8'hFF, "sat_ovr_b1");
        rd(16'd0, 8'h06, "sat_fcnt");
        rd(16'd6, 8'h00, "sat_status");
        chipselect = 1'b0;
        rd(16'd5, 8'hFF, "cs_low_read");
        rd(16'd0, 8'h06, "cs_low_fcnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
